// File: rtl/scan_pkg.sv
// scan_pkg: state encoding and schedule helpers
// shared by the SCAN stage scheduler files.
package scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DOWN,
    S_LEAF,
    S_UP,
    S_FIN
  } state_t;

  function automatic int tz(
    input logic [31:0] v,
    input int          w
  );
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (run && k < w) begin
        if (v[k]) run = 1'b0;
        else      n++;
      end
    end
    return n;
  endfunction

  function automatic int tones(
    input logic [31:0] v,
    input int          w
  );
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (run && k < w) begin
        if (!v[k]) run = 1'b0;
        else       n++;
      end
    end
    return n;
  endfunction

  function automatic int chunks(
    input int s,
    input int p_log
  );
    int c;
    c = (1 << s) >> p_log;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int chunk_w(
    input int n_log,
    input int p_log
  );
    return (n_log - 1 - p_log > 1) ?
           n_log - 1 - p_log : 1;
  endfunction

endpackage

// File: rtl/scan_sched_if.sv
// scan_sched_if: beat bus between the scheduler
// and the PE array (valid/ready plus op fields).
interface scan_sched_if
  import scan_pkg::*;
#(
  parameter int N_LOG = 3,
  parameter int P_LOG = 1
) ();

  localparam int SW = $clog2(N_LOG);
  localparam int CW = chunk_w(N_LOG, P_LOG);

  logic             pe_valid;
  logic             pe_ready;
  logic             pe_w1;
  logic             pe_w2;
  logic [SW-1:0]    pe_stage;
  logic [CW-1:0]    pe_chunk;
  logic [N_LOG-1:0] pe_leaf;
  logic             pe_up;
  logic             leaf_valid;

  modport master (
    output pe_valid, pe_w1, pe_w2,
    output pe_stage, pe_chunk, pe_leaf,
    output pe_up, leaf_valid,
    input  pe_ready
  );

  modport slave (
    input  pe_valid, pe_w1, pe_w2,
    input  pe_stage, pe_chunk, pe_leaf,
    input  pe_up, leaf_valid,
    output pe_ready
  );

endinterface

// File: rtl/scan_stage_seq.sv
// scan_stage_seq: walks tree stages (up or down)
// and the PE fold chunks inside each stage.
module scan_stage_seq
  import scan_pkg::*;
#(
  parameter int SW    = 2,
  parameter int CW    = 1,
  parameter int P_LOG = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic          dir_up,
  input  logic [SW-1:0] init,
  input  logic [SW-1:0] stop,
  output logic [SW-1:0] stage,
  output logic [CW-1:0] chunk,
  output logic          last
);

  logic chunk_end;

  assign chunk_end = (int'(chunk) ==
    chunks(int'(stage), P_LOG) - 1);
  assign last = chunk_end && (stage == stop);

  // stage/chunk counter: load on phase entry, step per beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
      chunk <= '0;
    end else if (load) begin
      stage <= init;
      chunk <= '0;
    end else if (step) begin
      if (chunk_end) begin
        chunk <= '0;
        stage <= dir_up ? stage + SW'(1)
                        : stage - SW'(1);
      end else begin
        chunk <= chunk + CW'(1);
      end
    end
  end

endmodule

// File: rtl/scan_sched.sv
// scan_sched: leaf-by-leaf SCAN decode scheduler
// issuing alpha/beta stage ops to a PE array.
module scan_sched
  import scan_pkg::*;
#(
  parameter int N_LOG  = 3,
  parameter int P_LOG  = 1,
  parameter int ITER_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_num,
  output logic [ITER_W-1:0] iter_idx,
  output logic              busy,
  output logic              done,
  scan_sched_if.master      bus
);

  localparam int SW = $clog2(N_LOG);
  localparam int CW = chunk_w(N_LOG, P_LOG);
  localparam logic [SW-1:0] TOP = SW'(N_LOG - 1);
  localparam logic [N_LOG-1:0] LAST = '1;

  state_t            state_q, state_d;
  logic [N_LOG-1:0]  leaf_q, leaf_d, leaf_nx;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] lim_q, lim_d;
  logic              seq_load, seq_step, seq_last;
  logic [SW-1:0]     seq_init, seq_stop, stage;
  logic [CW-1:0]     chunk;
  logic              beat, more, bit_s;
  logic              in_down, in_up;

  assign in_down = (state_q == S_DOWN);
  assign in_up   = (state_q == S_UP);
  assign beat    = bus.pe_valid & bus.pe_ready;
  assign leaf_nx = leaf_q + N_LOG'(1);
  assign more    = ({1'b0, iter_q} + (ITER_W+1)'(1))
                   < {1'b0, lim_q};
  assign seq_stop = in_up ?
    SW'(tones(32'(leaf_q), N_LOG) - 1) : '0;
  assign bit_s = |(leaf_q & (N_LOG'(1) << stage));

  scan_stage_seq #(
    .SW    (SW),
    .CW    (CW),
    .P_LOG (P_LOG)
  ) u_seq (
    .clk    (clk),
    .rst    (rst),
    .load   (seq_load),
    .step   (seq_step),
    .dir_up (in_up),
    .init   (seq_init),
    .stop   (seq_stop),
    .stage  (stage),
    .chunk  (chunk),
    .last   (seq_last)
  );

  // state, leaf, iteration and latched limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      leaf_q  <= '0;
      iter_q  <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      leaf_q  <= leaf_d;
      iter_q  <= iter_d;
      lim_q   <= lim_d;
    end
  end

  // next state: advance only on a retired beat
  always_comb begin
    state_d  = state_q;
    leaf_d   = leaf_q;
    iter_d   = iter_q;
    lim_d    = lim_q;
    seq_load = 1'b0;
    seq_step = 1'b0;
    seq_init = '0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_DOWN;
        leaf_d   = '0;
        iter_d   = '0;
        lim_d    = (iter_num == '0) ?
                   ITER_W'(1) : iter_num;
        seq_load = 1'b1;
        seq_init = TOP;
      end
      S_DOWN: if (beat) begin
        if (seq_last) state_d  = S_LEAF;
        else          seq_step = 1'b1;
      end
      S_LEAF: if (beat) begin
        seq_load = 1'b1;
        if (leaf_q[0]) begin
          state_d  = S_UP;
        end else begin
          state_d  = S_DOWN;
          leaf_d   = leaf_nx;
          seq_init = SW'(tz(32'(leaf_nx), N_LOG));
        end
      end
      S_UP: if (beat) begin
        if (!seq_last) begin
          seq_step = 1'b1;
        end else if (leaf_q != LAST) begin
          state_d  = S_DOWN;
          leaf_d   = leaf_nx;
          seq_load = 1'b1;
          seq_init = SW'(tz(32'(leaf_nx), N_LOG));
        end else if (more) begin
          state_d  = S_DOWN;
          leaf_d   = '0;
          iter_d   = iter_q + ITER_W'(1);
          seq_load = 1'b1;
          seq_init = TOP;
        end else begin
          state_d  = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        leaf_d  = '0;
        iter_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.pe_valid   = in_down | in_up |
                          (state_q == S_LEAF);
  assign bus.leaf_valid = (state_q == S_LEAF);
  assign bus.pe_up      = in_up;
  assign bus.pe_w1      = (in_down & ~bit_s) | in_up;
  assign bus.pe_w2      = (in_down & bit_s) | in_up;
  assign bus.pe_stage   = (in_down | in_up) ? stage : '0;
  assign bus.pe_chunk   = (in_down | in_up) ? chunk : '0;
  assign bus.pe_leaf    = bus.pe_valid ? leaf_q : '0;
  assign iter_idx       = iter_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FIN);

endmodule

// File: tb/tb_scan_sched.sv
// tb_scan_sched: drives scan_sched with random
// backpressure against a leaf-by-leaf schedule model.
module tb_scan_sched;

  localparam int N_LOG  = 3;
  localparam int P_LOG  = 1;
  localparam int ITER_W = 3;
  localparam int N      = 1 << N_LOG;
  localparam int SW     = $clog2(N_LOG);
  localparam int CW     = (N_LOG - 1 - P_LOG > 1) ?
                          N_LOG - 1 - P_LOG : 1;

  typedef struct packed {
    logic [ITER_W-1:0] iter;
    logic [N_LOG-1:0]  leaf;
    logic [SW-1:0]     stage;
    logic [CW-1:0]     chunk;
    logic              w1;
    logic              w2;
    logic              up;
    logic              lv;
    logic              busy;
  } beat_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iter_num;
  logic [ITER_W-1:0] iter_idx;
  int                tests;
  int                fails;
  beat_t             exp_q[$];

  scan_sched_if #(
    .N_LOG (N_LOG),
    .P_LOG (P_LOG)
  ) bus ();

  scan_sched #(
    .N_LOG  (N_LOG),
    .P_LOG  (P_LOG),
    .ITER_W (ITER_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .iter_num (iter_num),
    .iter_idx (iter_idx),
    .busy     (busy),
    .done     (done),
    .bus      (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ntz(input int v);
    int n;
    int x;
    n = 0;
    x = v;
    while (n < N_LOG && x % 2 == 0) begin
      x = x / 2;
      n++;
    end
    return n;
  endfunction

  function automatic int nto(input int v);
    int n;
    int x;
    n = 0;
    x = v;
    while (n < N_LOG && x % 2 == 1) begin
      x = x / 2;
      n++;
    end
    return n;
  endfunction

  function automatic int nchunks(input int s);
    int c;
    c = (2 ** s) / (2 ** P_LOG);
    return (c == 0) ? 1 : c;
  endfunction

  function automatic beat_t mk(
    input int it, input int i,
    input int s,  input int c,
    input bit w1, input bit w2,
    input bit up, input bit lv
  );
    beat_t b;
    b.iter  = ITER_W'(it);
    b.leaf  = N_LOG'(i);
    b.stage = SW'(s);
    b.chunk = CW'(c);
    b.w1    = w1;
    b.w2    = w2;
    b.up    = up;
    b.lv    = lv;
    b.busy  = 1'b1;
    return b;
  endfunction

  task automatic build(input int iters);
    int d;
    bit b;
    exp_q.delete();
    for (int it = 0; it < iters; it++) begin
      for (int i = 0; i < N; i++) begin
        d = (i == 0) ? N_LOG - 1 : ntz(i);
        for (int s = d; s >= 0; s--) begin
          b = ((i >> s) % 2) == 1;
          for (int c = 0; c < nchunks(s); c++)
            exp_q.push_back(
              mk(it, i, s, c, !b, b, 0, 0));
        end
        exp_q.push_back(mk(it, i, 0, 0, 0, 0, 0, 1));
        if (i % 2 == 1) begin
          for (int s = 0; s < nto(i); s++)
            for (int c = 0; c < nchunks(s); c++)
              exp_q.push_back(
                mk(it, i, s, c, 1, 1, 1, 0));
        end
      end
    end
  endtask

  function automatic beat_t sample();
    beat_t b;
    b.iter  = iter_idx;
    b.leaf  = bus.pe_leaf;
    b.stage = bus.pe_stage;
    b.chunk = bus.pe_chunk;
    b.w1    = bus.pe_w1;
    b.w2    = bus.pe_w2;
    b.up    = bus.pe_up;
    b.lv    = bus.leaf_valid;
    b.busy  = busy;
    return b;
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_beat(
    input string tag, input int k,
    input beat_t obs, input beat_t exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d]: observed %h expected %h",
             tag, k, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, 32'({bus.pe_valid, bus.pe_w1,
      bus.pe_w2, bus.leaf_valid, busy, done,
      bus.pe_stage, bus.pe_chunk, bus.pe_leaf,
      bus.pe_up, iter_idx}), 32'd0);
  endtask

  task automatic run(
    input  int iter_cfg, input int iters,
    input  int rdy_pct,  input int abort_at,
    input  bit poke,
    output int nd, output int nl, output int nu
  );
    int    k;
    int    dones;
    int    cyc;
    bit    exp_done;
    bit    hold;
    bit    aborted;
    beat_t snap;
    beat_t obs;
    build(iters);
    k = 0; dones = 0; cyc = 0;
    exp_done = 0; hold = 0; aborted = 0;
    nd = 0; nl = 0; nu = 0;
    snap = '0;
    iter_num = ITER_W'(iter_cfg);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 3000) begin
      bus.pe_ready = ($urandom_range(99) < rdy_pct);
      start = poke && (k == 5);
      if (start) iter_num = '1;
      @(negedge clk);
      obs = sample();
      if (hold) check_beat("hold", k, obs, snap);
      hold = 0;
      if (done) dones++;
      if (exp_done) begin
        check("done_pulse", 32'(done), 32'd1);
        check("fin_valid", 32'(bus.pe_valid), 32'd0);
        break;
      end
      if (bus.pe_valid) begin
        if (bus.pe_ready) begin
          if (k < exp_q.size())
            check_beat("beat", k, obs, exp_q[k]);
          else
            check("overrun", 32'(k),
                  32'(exp_q.size()));
          if (obs.lv)      nl++;
          else if (obs.up) nu++;
          else             nd++;
          k++;
          if (k == exp_q.size()) exp_done = 1;
          if (k == abort_at) begin
            #1 rst = 1'b1;
            #1 check_zero("rst_async");
            @(posedge clk); #1;
            rst = 1'b0;
            aborted = 1;
            break;
          end
        end else begin
          snap = obs;
          hold = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!aborted) begin
      check("beat_count", 32'(k), 32'(exp_q.size()));
      check("done_count", 32'(dones), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check_zero("idle");
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int nd;
    int nl;
    int nu;
    int n;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    start = 1'b0;
    iter_num = '0;
    bus.pe_ready = 1'b0;
    #1 rst = 1'b1;
    #1 check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run(1, 1, 100, -1, 0, nd, nl, nu);
    check("down_beats", 32'(nd), 32'd16);
    check("leaf_beats", 32'(nl), 32'd8);
    check("up_beats", 32'(nu), 32'd8);

    run(2, 2, 100, -1, 0, nd, nl, nu);
    check("multi_beats", 32'(nd + nl + nu), 32'd64);

    run(1, 1, 55, -1, 0, nd, nl, nu);
    check("bp_beats", 32'(nd + nl + nu), 32'd32);

    run(1, 1, 100, 10, 0, nd, nl, nu);
    run(1, 1, 100, -1, 0, nd, nl, nu);
    check("restart_beats", 32'(nd + nl + nu), 32'd32);

    run(0, 1, 100, -1, 1, nd, nl, nu);
    check("iter0_beats", 32'(nd + nl + nu), 32'd32);

    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(3, 1));
      run(n, n, int'($urandom_range(90, 40)),
          -1, 0, nd, nl, nu);
      check("rand_beats", 32'(nd + nl + nu),
            32'(32 * n));
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_sched.md
SCAN_SCHED -- requirements
Module: scan_sched

Interface
REQ-001 SHALL have parameter N_LOG, default 3, meaning log2 of the code length N; legal range 2..10.
REQ-002 SHALL have parameter P_LOG, default 1, meaning log2 of the PE count P of the attached PE array.
REQ-003 SHALL have parameter ITER_W, default 3, meaning the width of the iteration-count input.
REQ-004 Port: clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: start  in  1  begin decode; sampled in IDLE only.
REQ-007 Port: iter_num  in  ITER_W  SCAN iteration count, latched on start; a value of 0 is treated as 1.
REQ-008 Port: pe_ready  in  1  datapath accepts the current beat.
REQ-009 Port: pe_valid  out  1  the beat on the pe_* and leaf outputs is valid.
REQ-010 Port: pe_w1  out  1  drives the PE w1 (f1) enable.
REQ-011 Port: pe_w2  out  1  drives the PE w2 (f2) enable.
REQ-012 Port: pe_stage  out  clog2(N_LOG)  tree stage of the current op.
REQ-013 Port: pe_chunk  out  max(1,N_LOG-1-P_LOG)  PE fold index within the stage.
REQ-014 Port: pe_leaf  out  N_LOG  current leaf index i.
REQ-015 Port: pe_up  out  1  0 = alpha (down) op, 1 = beta (up) op.
REQ-016 Port: leaf_valid  out  1  leaf-decision beat.
REQ-017 Port: iter_idx  out  ITER_W  current iteration number, 0-based.
REQ-018 Port: busy  out  1  high while the FSM is outside IDLE.
REQ-019 Port: done  out  1  one-cycle pulse after the last beat of the last iteration.

Function
REQ-020 The FSM SHALL have the states IDLE, DOWN, LEAF, UP and FIN.
REQ-021 IDLE SHALL move to DOWN on start, with i=0, iter_idx=0 and stage=N_LOG-1.
REQ-022 Stage schedule per leaf i:
- DOWN covers stages d(i) down to 0, where d(0)=N_LOG-1 and d(i)=tz(i) (trailing zeros of i) otherwise.
- LEAF is exactly one beat.
- UP covers stages 0 to t(i)-1 only for odd i, where t(i) is the number of trailing ones of i.
- UP is skipped for even i.
REQ-023 Op enables:
- A DOWN op at stage s SHALL assert pe_w1 only if bit s of i is 0, and pe_w2 only if bit s of i is 1.
- UP ops SHALL assert both pe_w1 and pe_w2.
- LEAF beats SHALL assert neither.
REQ-024 Each stage s op SHALL take C(s)=max(1, 2^s >> P_LOG) beats, with pe_chunk counting 0..C(s)-1.
REQ-025 A beat SHALL retire only when pe_valid and pe_ready are both high; otherwise every output SHALL hold stable.
REQ-026 pe_valid SHALL be high in DOWN, LEAF and UP, and low in IDLE and FIN.
REQ-027 Transitions after the final beat of each phase:
- DOWN goes to LEAF.
- LEAF goes to UP if i is odd, otherwise to DOWN with i+1.
- UP goes to DOWN with i+1, or wraps at i=N-1.
REQ-028 Wrap at i=N-1:
- If iter_idx+1 < max(iter_num,1), the FSM SHALL return to DOWN with i=0 and iter_idx incremented.
- Otherwise it SHALL go to FIN.
REQ-029 FIN SHALL assert done for one cycle and then return to IDLE.
REQ-030 start while busy SHALL be ignored, and iter_num SHALL NOT be re-sampled.
REQ-031 With pe_ready held high, one iteration SHALL take exactly N + sum over all DOWN and UP ops of C(s) cycles.

Reset
REQ-032 rst SHALL force the following immediately, independent of clk:
- state IDLE
- all counters 0
- pe_valid, pe_w1, pe_w2, leaf_valid, busy, done all 0
- pe_stage, pe_chunk, pe_leaf, pe_up, iter_idx all 0
REQ-033 A rst mid-decode SHALL abandon the schedule; the next start SHALL restart at leaf 0, iteration 0.
REQ-034 The first start SHALL be honoured on the first clk edge after rst deasserts.

Structure
REQ-035 State encodings and the helper functions tz(), tones() and chunks() SHALL live in the shared package scan_pkg.
REQ-036 An optional sub-module scan_stage_seq (stage/chunk counter with a direction input) MAY be instantiated once each for DOWN and UP.
REQ-037 The block SHALL contain no datapath; pe_w1 and pe_w2 SHALL connect directly to the PE array enables.

Verification
REQ-038 Schedule check: N_LOG=3, P_LOG=1, iter_num=1, pe_ready=1 -> 32 valid beats, split as 16 DOWN, 8 LEAF and 8 UP; leaf 0 DOWN beats are stage/chunk/w = 2/0/w1, 2/1/w1, 1/0/w1, 0/0/w1; done pulses in the cycle after the last beat.
REQ-039 Leaf 7 UP check -> UP beats at stages 0, 1, 2, 2 (chunks 0, 0, 0, 1), with pe_w1=pe_w2=1 on every beat.
REQ-040 Multi-iteration check: iter_num=2 -> 64 beats; iter_idx steps 0->1 at leaf wrap; done pulses once.
REQ-041 Backpressure check: pe_ready toggled pseudo-randomly -> identical beat sequence to REQ-038 and no output change while pe_ready=0.
REQ-042 Reset-mid-decode check: rst asserted at beat 10 -> all outputs 0 immediately; a new start reproduces the REQ-038 sequence from beat 0.
REQ-043 Edge-case check: iter_num=0 -> behaves as 1 (32 beats); start pulsed while busy -> no effect.
